// File: rtl/dcache_controller_pkg.sv
// Shared definitions for the direct-mapped data cache controller.
// Contents: address-field widths, block width, FSM state encoding and a
// saturating increment helper used by the optional statistics counters.
package dcache_controller_pkg;

  localparam int ADDR_W     = 8;
  localparam int INDEX_W    = 3;
  localparam int OFFSET_W   = 2;
  localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES      = 1 << INDEX_W;
  localparam int BLOCK_W    = 32;
  localparam int MEM_ADDR_W = TAG_W + INDEX_W;
  localparam int STAT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FETCH     = 2'd2,
    ST_UPDATE    = 2'd3
  } state_e;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
    return (&value) ? value : value + STAT_W'(1);
  endfunction

endpackage

// File: rtl/dcache_controller_line_store.sv
// Line storage for the data cache: valid, dirty, tag and data arrays.
// Ports:
//   clk          clock
//   clear        synchronous clear of every valid and dirty bit
//   rd_index     asynchronous read index
//   rd_valid/rd_dirty/rd_tag/rd_line  contents of the selected line
//   wr_index     line selected by either write port
//   byte_we      store one byte (byte_offset, byte_data) and mark the line dirty
//   fill_we      replace the whole line (fill_tag, fill_line), valid=1, dirty=0
// Data and tag arrays are not cleared; only valid/dirty carry meaning after reset.
module dcache_controller_line_store
  import dcache_controller_pkg::*;
(
  input  logic                clk,
  input  logic                clear,
  input  logic [INDEX_W-1:0]  rd_index,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [BLOCK_W-1:0]  rd_line,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic                byte_we,
  input  logic [OFFSET_W-1:0] byte_offset,
  input  logic [7:0]          byte_data,
  input  logic                fill_we,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [BLOCK_W-1:0]  fill_line
);

  logic [LINES-1:0]   valid;
  logic [LINES-1:0]   dirty;
  logic [TAG_W-1:0]   tags  [LINES];
  logic [BLOCK_W-1:0] lines [LINES];

  assign rd_valid = valid[rd_index];
  assign rd_dirty = dirty[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_line  = lines[rd_index];

  always_ff @(posedge clk) begin
    if (clear) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_we) begin
      valid[wr_index] <= 1'b1;
      dirty[wr_index] <= 1'b0;
    end else if (byte_we) begin
      dirty[wr_index] <= 1'b1;
    end
  end

  // Refill wins over a byte store; the controller never issues both at once.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tags[wr_index]  <= fill_tag;
      lines[wr_index] <= fill_line;
    end else if (byte_we) begin
      lines[wr_index][{byte_offset, 3'b000} +: 8] <= byte_data;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller between
// an 8-bit CPU and a word-wide data memory.
// Ports:
//   CLK, RESET (synchronous, active-low)
//   READ, WRITE, ADDRESS, WRITEDATA   CPU request (READ+WRITE together = write)
//   READDATA, BUSYWAIT                CPU load data (combinational) and stall
//   MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA   registered block request
//   MEM_READDATA, MEM_BUSYWAIT        memory response
//   HIT_COUNT, MISS_COUNT             present only with DCACHE_STATS_EN defined
// Optional feature macro: DCACHE_STATS_EN (saturating hit/miss counters).
module dcache_controller
  import dcache_controller_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_W-1:0]     ADDRESS,
  input  logic [7:0]            WRITEDATA,
  output logic [7:0]            READDATA,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
  output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]    MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [STAT_W-1:0]     HIT_COUNT,
  output logic [STAT_W-1:0]     MISS_COUNT
`endif
);

  state_e state, next_state;
  logic   settled;

  logic [TAG_W-1:0]    cpu_tag;
  logic [INDEX_W-1:0]  cpu_index;
  logic [OFFSET_W-1:0] cpu_offset;
  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_index;

  logic                rd_valid, rd_dirty;
  logic [TAG_W-1:0]    rd_tag;
  logic [BLOCK_W-1:0]  rd_line;
  logic [INDEX_W-1:0]  rd_index, wr_index;
  logic                request, hit, byte_we, fill_we;

  logic                  mem_read_d, mem_write_d;
  logic [MEM_ADDR_W-1:0] mem_address_d;
  logic [BLOCK_W-1:0]    mem_writedata_d;

  assign cpu_tag    = ADDRESS[ADDR_W-1 -: TAG_W];
  assign cpu_index  = ADDRESS[OFFSET_W +: INDEX_W];
  assign cpu_offset = ADDRESS[OFFSET_W-1:0];
  assign request    = READ | WRITE;

  // Outside IDLE the line of interest is the latched miss, not the live bus.
  assign rd_index = (state == ST_IDLE) ? cpu_index : req_index;
  assign wr_index = (state == ST_UPDATE) ? req_index : cpu_index;

  assign hit      = rd_valid & (&(rd_tag ~^ cpu_tag));
  assign BUSYWAIT = request & ~((state == ST_IDLE) & hit);
  assign READDATA = rd_line[{cpu_offset, 3'b000} +: 8];

  assign byte_we = RESET & (state == ST_IDLE) & WRITE & hit;
  assign fill_we = RESET & (state == ST_UPDATE);

  dcache_controller_line_store u_line_store (
    .clk         (CLK),
    .clear       (~RESET),
    .rd_index    (rd_index),
    .rd_valid    (rd_valid),
    .rd_dirty    (rd_dirty),
    .rd_tag      (rd_tag),
    .rd_line     (rd_line),
    .wr_index    (wr_index),
    .byte_we     (byte_we),
    .byte_offset (cpu_offset),
    .byte_data   (WRITEDATA),
    .fill_we     (fill_we),
    .fill_tag    (req_tag),
    .fill_line   (MEM_READDATA)
  );

  // Next state and the memory request to hold during that next state.
  // The memory is only trusted from the second cycle of a state (settled),
  // since its busy flag may not yet reflect the request just issued.
  always_comb begin
    next_state      = state;
    mem_read_d      = 1'b0;
    mem_write_d     = 1'b0;
    mem_address_d   = '0;
    mem_writedata_d = '0;
    case (state)
      ST_IDLE: begin
        if (request && !hit) begin
          if (rd_dirty) begin
            next_state      = ST_WRITEBACK;
            mem_write_d     = 1'b1;
            mem_address_d   = {rd_tag, cpu_index};
            mem_writedata_d = rd_line;
          end else begin
            next_state    = ST_FETCH;
            mem_read_d    = 1'b1;
            mem_address_d = {cpu_tag, cpu_index};
          end
        end
      end
      ST_WRITEBACK: begin
        if (settled && !MEM_BUSYWAIT) begin
          next_state    = ST_FETCH;
          mem_read_d    = 1'b1;
          mem_address_d = {req_tag, req_index};
        end else begin
          mem_write_d     = 1'b1;
          mem_address_d   = {rd_tag, req_index};
          mem_writedata_d = rd_line;
        end
      end
      ST_FETCH: begin
        if (settled && !MEM_BUSYWAIT) begin
          next_state = ST_UPDATE;
        end else begin
          mem_read_d    = 1'b1;
          mem_address_d = {req_tag, req_index};
        end
      end
      ST_UPDATE: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state         <= ST_IDLE;
      settled       <= 1'b0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
    end else begin
      state         <= next_state;
      settled       <= (next_state == state);
      MEM_READ      <= mem_read_d;
      MEM_WRITE     <= mem_write_d;
      MEM_ADDRESS   <= mem_address_d;
      MEM_WRITEDATA <= mem_writedata_d;
    end
  end

  // Miss latched on IDLE exit; the CPU bus is not relied on afterwards.
  always_ff @(posedge CLK) begin
    if ((state == ST_IDLE) && (next_state != ST_IDLE)) begin
      req_tag   <= cpu_tag;
      req_index <= cpu_index;
    end
  end

`ifdef DCACHE_STATS_EN
  logic hit_accept, miss_start;

  assign hit_accept = (state == ST_IDLE) & request & hit;
  assign miss_start = (state == ST_IDLE) & request & ~hit;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      HIT_COUNT  <= '0;
      MISS_COUNT <= '0;
    end else begin
      if (hit_accept) HIT_COUNT  <= sat_inc(HIT_COUNT);
      if (miss_start) MISS_COUNT <= sat_inc(MISS_COUNT);
    end
  end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Testbench for dcache_controller: directed scenarios followed by random
// loads/stores, checked against a line-level cache model and a backing
// memory model kept in the bench. DCACHE_STATS_EN enables counter checks.
module tb_dcache_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        read, write;
  logic [7:0]  address, writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read, mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  dcache_controller dut (
    .CLK           (clk),
    .RESET         (reset),
    .READ          (read),
    .WRITE         (write),
    .ADDRESS       (address),
    .WRITEDATA     (writedata),
    .READDATA      (readdata),
    .BUSYWAIT      (busywait),
    .MEM_READ      (mem_read),
    .MEM_WRITE     (mem_write),
    .MEM_ADDRESS   (mem_address),
    .MEM_WRITEDATA (mem_writedata),
    .MEM_READDATA  (mem_readdata),
    .MEM_BUSYWAIT  (mem_busywait)
`ifdef DCACHE_STATS_EN
    ,
    .HIT_COUNT     (hit_count),
    .MISS_COUNT    (miss_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory: busy for 5 cycles after a request appears, then ready for one.
  logic [31:0] mem_arr [64];
  logic [1:0]  mem_kind = 2'b00;
  int          mem_cnt = 0;
  int          wb_count = 0, fetch_count = 0;
  logic [5:0]  wb_addr, fetch_addr;
  logic [31:0] wb_data;
  logic        both_seen = 1'b0;

  always @(negedge clk) begin
    if (mem_read && mem_write) both_seen = 1'b1;
    if (!(mem_read || mem_write)) begin
      mem_busywait = 1'b0;
      mem_cnt      = 0;
      mem_kind     = 2'b00;
    end else if ({mem_read, mem_write} != mem_kind) begin
      mem_kind     = {mem_read, mem_write};
      mem_cnt      = 5;
      mem_busywait = 1'b1;
      if (mem_write) begin
        wb_count++;
        wb_addr = mem_address;
        wb_data = mem_writedata;
      end else begin
        fetch_count++;
        fetch_addr = mem_address;
      end
    end else if (mem_cnt > 1) begin
      mem_cnt--;
    end else if (mem_cnt == 1) begin
      mem_cnt      = 0;
      mem_busywait = 1'b0;
      if (mem_write) mem_arr[mem_address] = mem_writedata;
      else           mem_readdata = mem_arr[mem_address];
    end
  end

  // Reference model: per-line state plus an independent copy of memory.
  logic [31:0] ref_mem [64];
  logic        m_valid [8];
  logic        m_dirty [8];
  logic [2:0]  m_tag   [8];
  logic [31:0] m_data  [8];
  int          m_hits = 0, m_misses = 0;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  // One CPU access, started and finished 1 time unit after a posedge.
  task automatic do_op(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    logic [2:0]  idx, tg;
    int          off, wb0, f0, n;
    logic        exp_hit, exp_wb;
    logic [5:0]  wba;
    logic [31:0] wbd;
    idx = a[4:2];
    tg  = a[7:5];
    off = int'(a[1:0]);
    exp_hit = m_valid[idx] && (m_tag[idx] == tg);
    exp_wb  = !exp_hit && m_dirty[idx];
    wba = {m_tag[idx], idx};
    wbd = m_data[idx];
    wb0 = wb_count;
    f0  = fetch_count;
    read = rd; write = wr; address = a; writedata = d;
    #1;
    chk("stall", 32'(busywait), 32'(!exp_hit));
    if (!exp_hit) begin
      n = 0;
      while (busywait && n < 60) begin
        @(posedge clk); #1;
        n++;
      end
      chk("miss_done", 32'(busywait), 32'd0);
      chk("wb_cnt", 32'(wb_count - wb0), 32'(exp_wb));
      chk("fetch_cnt", 32'(fetch_count - f0), 32'd1);
      if (exp_wb) begin
        chk("wb_addr", 32'(wb_addr), 32'(wba));
        chk("wb_data", wb_data, wbd);
        ref_mem[wba] = wbd;
      end
      chk("fetch_addr", 32'(fetch_addr), 32'({tg, idx}));
      m_data[idx]  = ref_mem[{tg, idx}];
      m_tag[idx]   = tg;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_misses++;
    end
    if (wr) begin
      m_data[idx][off*8 +: 8] = d;
      m_dirty[idx] = 1'b1;
    end else begin
      chk("rdata", 32'(readdata), 32'(m_data[idx][off*8 +: 8]));
    end
    m_hits++;
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb0, n;
    logic [1:0] k;
    reset = 1'b0; read = 1'b0; write = 1'b0; address = 8'h00; writedata = 8'h00;
    mem_busywait = 1'b0; mem_readdata = 32'h0;
    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[9] = 32'hDDCCBBAA;
    ref_mem[9] = 32'hDDCCBBAA;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busywait), 32'd0);
    chk("rst_mread", 32'(mem_read), 32'd0);
    chk("rst_mwrite", 32'(mem_write), 32'd0);
    chk("rst_maddr", 32'(mem_address), 32'd0);
    chk("rst_mwdata", mem_writedata, 32'd0);
    read = 1'b1; #1;
    chk("rst_busy_req", 32'(busywait), 32'd1);
    read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // 1: cold read miss, refill, then hit
    do_op(1'b1, 1'b0, 8'h25, 8'h00);
    chk("t1_faddr", 32'(fetch_addr), 32'h09);
    chk("t1_rdata", 32'(readdata), 32'hBB);
    do_op(1'b1, 1'b0, 8'h25, 8'h00);

    // 2: write hit, read back
    do_op(1'b0, 1'b1, 8'h25, 8'h5A);
    do_op(1'b1, 1'b0, 8'h25, 8'h00);
    chk("t2_rdata", 32'(readdata), 32'h5A);

    // 3: dirty eviction
    do_op(1'b1, 1'b0, 8'h45, 8'h00);
    chk("t3_wbaddr", 32'(wb_addr), 32'h09);
    chk("t3_wbdata", wb_data, 32'hDDCC5AAA);
    chk("t3_faddr", 32'(fetch_addr), 32'h11);

    // 4: reset in the middle of a fetch
    read = 1'b1; address = 8'h65;
    n = 0;
    while (!mem_read && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t4_fetch", 32'(mem_read), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("t4_rst_mread", 32'(mem_read), 32'd0);
    chk("t4_rst_busy", 32'(busywait), 32'd1);
    reset = 1'b1; read = 1'b0;
    model_reset();
    @(posedge clk); #1;
    do_op(1'b1, 1'b0, 8'h25, 8'h00);

    // 5: READ and WRITE together on a hit line act as a write
    do_op(1'b1, 1'b1, 8'h25, 8'h77);
    do_op(1'b1, 1'b0, 8'h25, 8'h00);
    chk("t5_rdata", 32'(readdata), 32'h77);
    wb0 = wb_count;
    do_op(1'b1, 1'b0, 8'h45, 8'h00);
    chk("t5_evict", 32'(wb_count - wb0), 32'd1);

    // Random traffic over four tags to mix hits, clean and dirty misses
    for (int i = 0; i < 250; i++) begin
      k = 2'($urandom_range(0, 3));
      do_op(k != 2'd1, k == 2'd1 || k == 2'd2, 8'($urandom_range(0, 127)), 8'($urandom));
    end
    chk("mem_excl", 32'(both_seen), 32'd0);

`ifdef DCACHE_STATS_EN
    chk("stat_hits", 32'(hit_count), 32'(sat16(m_hits)));
    chk("stat_misses", 32'(miss_count), 32'(sat16(m_misses)));
    do_op(1'b1, 1'b0, 8'h25, 8'h00);
    read = 1'b1; address = 8'h25;
    for (int i = 0; i < 65600; i++) @(posedge clk);
    #1;
    read = 1'b0;
    chk("stat_hit_sat", 32'(hit_count), 32'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
